inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder_pkg.sv | 141 ++++++++++++++
 rtl/enc_fifo.sv | 47 ++++
 rtl/inst_encoder.sv | 112 +++++++++++
 tb/tb_inst_encoder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/inst_encoder_pkg.sv
// Shared operation header: op codes, operation classes, the NULL register marker
// and the RV32I major opcodes, plus the per-op field lookup used by the encoder.
package inst_encoder_pkg;

  localparam logic [5:0] OP_ADDI  = 6'd0;
  localparam logic [5:0] OP_SLTI  = 6'd1;
  localparam logic [5:0] OP_SLTIU = 6'd2;
  localparam logic [5:0] OP_XORI  = 6'd3;
  localparam logic [5:0] OP_ORI   = 6'd4;
  localparam logic [5:0] OP_ANDI  = 6'd5;
  localparam logic [5:0] OP_SLLI  = 6'd6;
  localparam logic [5:0] OP_SRLI  = 6'd7;
  localparam logic [5:0] OP_SRAI  = 6'd8;
  localparam logic [5:0] OP_LB    = 6'd9;
  localparam logic [5:0] OP_LH    = 6'd10;
  localparam logic [5:0] OP_LW    = 6'd11;
  localparam logic [5:0] OP_LBU   = 6'd12;
  localparam logic [5:0] OP_LHU   = 6'd13;
  localparam logic [5:0] OP_SB    = 6'd14;
  localparam logic [5:0] OP_SH    = 6'd15;
  localparam logic [5:0] OP_SW    = 6'd16;
  localparam logic [5:0] OP_BEQ   = 6'd17;
  localparam logic [5:0] OP_BNE   = 6'd18;
  localparam logic [5:0] OP_BLT   = 6'd19;
  localparam logic [5:0] OP_BGE   = 6'd20;
  localparam logic [5:0] OP_BLTU  = 6'd21;
  localparam logic [5:0] OP_BGEU  = 6'd22;
  localparam logic [5:0] OP_LUI   = 6'd23;
  localparam logic [5:0] OP_AUIPC = 6'd24;
  localparam logic [5:0] OP_JAL   = 6'd25;
  localparam logic [5:0] OP_JALR  = 6'd26;
  localparam logic [5:0] OP_ADD   = 6'd27;
  localparam logic [5:0] OP_SUB   = 6'd28;
  localparam logic [5:0] OP_SLL   = 6'd29;
  localparam logic [5:0] OP_SLT   = 6'd30;
  localparam logic [5:0] OP_SLTU  = 6'd31;
  localparam logic [5:0] OP_XOR   = 6'd32;
  localparam logic [5:0] OP_SRL   = 6'd33;
  localparam logic [5:0] OP_SRA   = 6'd34;
  localparam logic [5:0] OP_OR    = 6'd35;
  localparam logic [5:0] OP_AND   = 6'd36;

  localparam logic [5:0] NULL_REG = 6'b100000;

  typedef enum logic [2:0] {
    OPT_ITYPE = 3'd0,
    OPT_ILOAD = 3'd1,
    OPT_STYPE = 3'd2,
    OPT_BTYPE = 3'd3,
    OPT_UTYPE = 3'd4,
    OPT_JTYPE = 3'd5,
    OPT_RTYPE = 3'd6
  } op_type_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0]  F7_BASE  = 7'b0000000;
  localparam logic [6:0]  F7_ALT   = 7'b0100000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic       known;
    op_type_e   op_type;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_shift;
  } op_info_t;

  function automatic op_info_t mk(input op_type_e t, input logic [6:0] opc,
                                  input logic [2:0] f3, input logic [6:0] f7,
                                  input logic sh);
    op_info_t info;
    info.known    = 1'b1;
    info.op_type  = t;
    info.opcode   = opc;
    info.funct3   = f3;
    info.funct7   = f7;
    info.is_shift = sh;
    return info;
  endfunction

  function automatic op_info_t op_info(input logic [5:0] op);
    op_info_t info;
    info = '0;
    case (op)
      OP_ADDI:  info = mk(OPT_ITYPE, OPC_OP_IMM, 3'b000, F7_BASE, 1'b0);
      OP_SLTI:  info = mk(OPT_ITYPE, OPC_OP_IMM, 3'b010, F7_BASE, 1'b0);
      OP_SLTIU: info = mk(OPT_ITYPE, OPC_OP_IMM, 3'b011, F7_BASE, 1'b0);
      OP_XORI:  info = mk(OPT_ITYPE, OPC_OP_IMM, 3'b100, F7_BASE, 1'b0);
      OP_ORI:   info = mk(OPT_ITYPE, OPC_OP_IMM, 3'b110, F7_BASE, 1'b0);
      OP_ANDI:  info = mk(OPT_ITYPE, OPC_OP_IMM, 3'b111, F7_BASE, 1'b0);
      OP_SLLI:  info = mk(OPT_ITYPE, OPC_OP_IMM, 3'b001, F7_BASE, 1'b1);
      OP_SRLI:  info = mk(OPT_ITYPE, OPC_OP_IMM, 3'b101, F7_BASE, 1'b1);
      OP_SRAI:  info = mk(OPT_ITYPE, OPC_OP_IMM, 3'b101, F7_ALT,  1'b1);
      OP_LB:    info = mk(OPT_ILOAD, OPC_LOAD,   3'b000, F7_BASE, 1'b0);
      OP_LH:    info = mk(OPT_ILOAD, OPC_LOAD,   3'b001, F7_BASE, 1'b0);
      OP_LW:    info = mk(OPT_ILOAD, OPC_LOAD,   3'b010, F7_BASE, 1'b0);
      OP_LBU:   info = mk(OPT_ILOAD, OPC_LOAD,   3'b100, F7_BASE, 1'b0);
      OP_LHU:   info = mk(OPT_ILOAD, OPC_LOAD,   3'b101, F7_BASE, 1'b0);
      OP_SB:    info = mk(OPT_STYPE, OPC_STORE,  3'b000, F7_BASE, 1'b0);
      OP_SH:    info = mk(OPT_STYPE, OPC_STORE,  3'b001, F7_BASE, 1'b0);
      OP_SW:    info = mk(OPT_STYPE, OPC_STORE,  3'b010, F7_BASE, 1'b0);
      OP_BEQ:   info = mk(OPT_BTYPE, OPC_BRANCH, 3'b000, F7_BASE, 1'b0);
      OP_BNE:   info = mk(OPT_BTYPE, OPC_BRANCH, 3'b001, F7_BASE, 1'b0);
      OP_BLT:   info = mk(OPT_BTYPE, OPC_BRANCH, 3'b100, F7_BASE, 1'b0);
      OP_BGE:   info = mk(OPT_BTYPE, OPC_BRANCH, 3'b101, F7_BASE, 1'b0);
      OP_BLTU:  info = mk(OPT_BTYPE, OPC_BRANCH, 3'b110, F7_BASE, 1'b0);
      OP_BGEU:  info = mk(OPT_BTYPE, OPC_BRANCH, 3'b111, F7_BASE, 1'b0);
      OP_LUI:   info = mk(OPT_UTYPE, OPC_LUI,    3'b000, F7_BASE, 1'b0);
      OP_AUIPC: info = mk(OPT_UTYPE, OPC_AUIPC,  3'b000, F7_BASE, 1'b0);
      OP_JAL:   info = mk(OPT_JTYPE, OPC_JAL,    3'b000, F7_BASE, 1'b0);
      OP_JALR:  info = mk(OPT_ITYPE, OPC_JALR,   3'b000, F7_BASE, 1'b0);
      OP_ADD:   info = mk(OPT_RTYPE, OPC_OP,     3'b000, F7_BASE, 1'b0);
      OP_SUB:   info = mk(OPT_RTYPE, OPC_OP,     3'b000, F7_ALT,  1'b0);
      OP_SLL:   info = mk(OPT_RTYPE, OPC_OP,     3'b001, F7_BASE, 1'b0);
      OP_SLT:   info = mk(OPT_RTYPE, OPC_OP,     3'b010, F7_BASE, 1'b0);
      OP_SLTU:  info = mk(OPT_RTYPE, OPC_OP,     3'b011, F7_BASE, 1'b0);
      OP_XOR:   info = mk(OPT_RTYPE, OPC_OP,     3'b100, F7_BASE, 1'b0);
      OP_SRL:   info = mk(OPT_RTYPE, OPC_OP,     3'b101, F7_BASE, 1'b0);
      OP_SRA:   info = mk(OPT_RTYPE, OPC_OP,     3'b101, F7_ALT,  1'b0);
      OP_OR:    info = mk(OPT_RTYPE, OPC_OP,     3'b110, F7_BASE, 1'b0);
      OP_AND:   info = mk(OPT_RTYPE, OPC_OP,     3'b111, F7_BASE, 1'b0);
      default:  info = '0;
    endcase
    return info;
  endfunction

  function automatic logic [4:0] reg_field(input logic [5:0] r);
    return r[5] ? 5'd0 : r[4:0];
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Two-entry FIFO holding encoded words; the parent guarantees no push when full
// and no pop when empty.
module enc_fifo #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; the parent masks the read data while empty,
  // so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/inst_encoder.sv
// Encodes a decoded instruction into an RV32I word (NOP + illegal flag when it
// cannot be encoded) and buffers {inst, illegal} in a two-entry FIFO.
module inst_encoder
  import inst_encoder_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  op_in,
  input  logic [2:0]  op_type_in,
  input  logic [5:0]  rs1_in,
  input  logic [5:0]  rs2_in,
  input  logic [5:0]  rd_in,
  input  logic [31:0] imm_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] inst_out,
  output logic        illegal_out
);

  op_info_t    w_info;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic        w_sext12, w_sext13, w_sext21;
  logic [31:0] w_word;
  logic        w_imm_ok;
  logic        w_illegal;
  logic [31:0] w_inst;

  // NOTE: combinational logic uses blocking '=' and assigns every output a
  // default first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    w_info   = op_info(op_in);
    w_rs1    = reg_field(rs1_in);
    w_rs2    = reg_field(rs2_in);
    w_rd     = reg_field(rd_in);
    w_sext12 = (&imm_in[31:11]) | ~(|imm_in[31:11]);
    w_sext13 = (&imm_in[31:12]) | ~(|imm_in[31:12]);
    w_sext21 = (&imm_in[31:20]) | ~(|imm_in[31:20]);
    w_word   = '0;
    w_imm_ok = 1'b0;
    case (w_info.op_type)
      OPT_ITYPE, OPT_ILOAD: begin
        if (w_info.is_shift) begin
          w_word   = {w_info.funct7, imm_in[4:0], w_rs1, w_info.funct3, w_rd, w_info.opcode};
          w_imm_ok = (imm_in[31:5] == '0);
        end else begin
          w_word   = {imm_in[11:0], w_rs1, w_info.funct3, w_rd, w_info.opcode};
          w_imm_ok = w_sext12;
        end
      end
      OPT_STYPE: begin
        w_word   = {imm_in[11:5], w_rs2, w_rs1, w_info.funct3, imm_in[4:0], w_info.opcode};
        w_imm_ok = w_sext12;
      end
      OPT_BTYPE: begin
        w_word   = {imm_in[12], imm_in[10:5], w_rs2, w_rs1, w_info.funct3,
                    imm_in[4:1], imm_in[11], w_info.opcode};
        w_imm_ok = w_sext13 & ~imm_in[0];
      end
      OPT_UTYPE: begin
        w_word   = {imm_in[31:12], w_rd, w_info.opcode};
        w_imm_ok = (imm_in[11:0] == '0);
      end
      OPT_JTYPE: begin
        w_word   = {imm_in[20], imm_in[10:1], imm_in[11], imm_in[19:12], w_rd, w_info.opcode};
        w_imm_ok = w_sext21 & ~imm_in[0];
      end
      OPT_RTYPE: begin
        w_word   = {w_info.funct7, w_rs2, w_rs1, w_info.funct3, w_rd, w_info.opcode};
        w_imm_ok = 1'b1;
      end
      default: begin
        w_word   = '0;
        w_imm_ok = 1'b0;
      end
    endcase
    w_illegal = ~w_info.known | (op_type_in != w_info.op_type) | ~w_imm_ok;
    w_inst    = w_illegal ? NOP_INST : w_word;
  end

  // Holds in_ready low through reset and until the first edge after release.
  logic r_init;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_init <= 1'b0;
    else           r_init <= 1'b1;
  end

  logic        w_push, w_pop;
  logic [1:0]  w_count;
  logic [32:0] w_rdata;

  assign in_ready  = r_init & (w_count != 2'd2);
  assign out_valid = (w_count != 2'd0);
  assign w_push    = rdy_in & in_valid & in_ready;
  assign w_pop     = rdy_in & out_valid & out_ready;

  enc_fifo #(.W(33)) u_fifo (
    .clk     (clk_in),
    .rst_n   (rst_n_in),
    .i_push  (w_push),
    .i_wdata ({w_inst, w_illegal}),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_count (w_count)
  );

  assign inst_out    = out_valid ? w_rdata[32:1] : 32'd0;
  assign illegal_out = out_valid & w_rdata[0];

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: hand-encoded RV32I words, illegal cases,
// FIFO backpressure, rdy_in freeze and mid-operation reset.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in, in_valid, in_ready, out_valid, out_ready, illegal_out;
  logic [5:0]  op_in, rs1_in, rs2_in, rd_in;
  logic [2:0]  op_type_in;
  logic [31:0] imm_in, inst_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_in = ~clk_in;

  inst_encoder dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .rdy_in      (rdy_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_in       (op_in),
    .op_type_in  (op_type_in),
    .rs1_in      (rs1_in),
    .rs2_in      (rs2_in),
    .rd_in       (rd_in),
    .imm_in      (imm_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .inst_out    (inst_out),
    .illegal_out (illegal_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_req(input logic [5:0] op, input logic [2:0] typ, input logic [5:0] rs1,
                         input logic [5:0] rs2, input logic [5:0] rd, input logic [31:0] imm);
    op_in      = op;
    op_type_in = typ;
    rs1_in     = rs1;
    rs2_in     = rs2;
    rd_in      = rd;
    imm_in     = imm;
    in_valid   = 1'b1;
  endtask

  // Push one request into an empty FIFO, check the word one cycle later, then drain it.
  task automatic enc_case(input string tag, input logic [5:0] op, input logic [2:0] typ,
                          input logic [5:0] rs1, input logic [5:0] rs2, input logic [5:0] rd,
                          input logic [31:0] imm, input logic [31:0] exp_inst, input logic exp_ill);
    set_req(op, typ, rs1, rs2, rd, imm);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, " valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, " inst"}, inst_out, exp_inst);
    check({tag, " illegal"}, {31'd0, illegal_out}, {31'd0, exp_ill});
    tick();
    check({tag, " drained"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst_n_in  = 1'b1;
    rdy_in    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_req(OP_ADDI, OPT_ITYPE, 6'd0, NULL_REG, 6'd0, 32'd0);
    in_valid  = 1'b0;
    #2 rst_n_in = 1'b0;
    #5;
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst in_ready", {31'd0, in_ready}, 32'd0);
    check("rst inst_out", inst_out, 32'd0);
    check("rst illegal_out", {31'd0, illegal_out}, 32'd0);
    #6 rst_n_in = 1'b1;
    tick();
    check("post-rst in_ready", {31'd0, in_ready}, 32'd1);
    check("post-rst out_valid", {31'd0, out_valid}, 32'd0);

    // Legal encodings
    enc_case("addi", OP_ADDI, OPT_ITYPE, 6'd0, NULL_REG, 6'd1, 32'd5, 32'h0050_0093, 1'b0);
    enc_case("sub",  OP_SUB,  OPT_RTYPE, 6'd1, 6'd2, 6'd3, 32'd0, 32'h4020_81B3, 1'b0);
    enc_case("beq",  OP_BEQ,  OPT_BTYPE, 6'd1, 6'd2, NULL_REG, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
    enc_case("jal",  OP_JAL,  OPT_JTYPE, NULL_REG, NULL_REG, 6'd1, 32'd8, 32'h0080_00EF, 1'b0);
    enc_case("sw",   OP_SW,   OPT_STYPE, 6'd1, 6'd2, NULL_REG, 32'd12, 32'h0020_A623, 1'b0);
    enc_case("lui",  OP_LUI,  OPT_UTYPE, NULL_REG, NULL_REG, 6'd5, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    enc_case("srai", OP_SRAI, OPT_ITYPE, 6'd3, NULL_REG, 6'd2, 32'd4, 32'h4041_D113, 1'b0);
    enc_case("lw",   OP_LW,   OPT_ILOAD, 6'd2, NULL_REG, 6'd4, 32'hFFFF_FFF8, 32'hFF81_2203, 1'b0);
    enc_case("add null rs1", OP_ADD, OPT_RTYPE, NULL_REG, 6'd2, 6'd1, 32'd0, 32'h0020_00B3, 1'b0);
    enc_case("slli max", OP_SLLI, OPT_ITYPE, 6'd1, NULL_REG, 6'd1, 32'd31, 32'h01F0_9093, 1'b0);
    enc_case("addi min", OP_ADDI, OPT_ITYPE, 6'd0, NULL_REG, 6'd1, 32'hFFFF_F800, 32'h8000_0093, 1'b0);

    // Illegal requests
    enc_case("beq odd", OP_BEQ, OPT_BTYPE, 6'd1, 6'd2, NULL_REG, 32'd3, NOP_INST, 1'b1);
    enc_case("addi 0x800", OP_ADDI, OPT_ITYPE, 6'd0, NULL_REG, 6'd1, 32'h0000_0800, NOP_INST, 1'b1);
    enc_case("type mismatch", OP_ADD, OPT_ITYPE, 6'd1, 6'd2, 6'd3, 32'd0, NOP_INST, 1'b1);
    enc_case("unknown op", 6'd63, OPT_RTYPE, 6'd1, 6'd2, 6'd3, 32'd0, NOP_INST, 1'b1);
    enc_case("slli big", OP_SLLI, OPT_ITYPE, 6'd1, NULL_REG, 6'd1, 32'd32, NOP_INST, 1'b1);
    enc_case("auipc low", OP_AUIPC, OPT_UTYPE, NULL_REG, NULL_REG, 6'd1, 32'h0000_1001, NOP_INST, 1'b1);

    // Backpressure: three back-to-back requests with the consumer stalled
    out_ready = 1'b0;
    set_req(OP_ADDI, OPT_ITYPE, 6'd0, NULL_REG, 6'd1, 32'd1);
    tick();
    check("bp in_ready after 1", {31'd0, in_ready}, 32'd1);
    set_req(OP_ADDI, OPT_ITYPE, 6'd0, NULL_REG, 6'd1, 32'd2);
    tick();
    check("bp in_ready after 2", {31'd0, in_ready}, 32'd0);
    check("bp head A", inst_out, 32'h0010_0093);
    set_req(OP_ADDI, OPT_ITYPE, 6'd0, NULL_REG, 6'd1, 32'd3);
    tick();
    check("bp still full", {31'd0, in_ready}, 32'd0);
    check("bp head A held", inst_out, 32'h0010_0093);
    out_ready = 1'b1;
    tick();
    check("bp word B", inst_out, 32'h0020_0093);
    check("bp in_ready reopened", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp word C", inst_out, 32'h0030_0093);
    check("bp push+pop valid", {31'd0, out_valid}, 32'd1);
    tick();
    check("bp drained", {31'd0, out_valid}, 32'd0);

    // Freeze: rdy_in low with one word buffered, push and pop both requested
    out_ready = 1'b0;
    set_req(OP_ADDI, OPT_ITYPE, 6'd0, NULL_REG, 6'd2, 32'd7);
    tick();
    rdy_in    = 1'b0;
    out_ready = 1'b1;
    set_req(OP_ADDI, OPT_ITYPE, 6'd0, NULL_REG, 6'd2, 32'd9);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("frz out_valid", {31'd0, out_valid}, 32'd1);
      check("frz inst_out", inst_out, 32'h0070_0113);
      check("frz in_ready", {31'd0, in_ready}, 32'd1);
    end
    rdy_in    = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("frz resumed full", {31'd0, in_ready}, 32'd0);
    check("frz resumed head", inst_out, 32'h0070_0113);

    // Reset with two words buffered
    rst_n_in = 1'b0;
    #1;
    check("mid-rst out_valid", {31'd0, out_valid}, 32'd0);
    check("mid-rst in_ready", {31'd0, in_ready}, 32'd0);
    check("mid-rst inst_out", inst_out, 32'd0);
    #1 rst_n_in = 1'b1;
    tick();
    check("after mid-rst in_ready", {31'd0, in_ready}, 32'd1);
    check("after mid-rst out_valid", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
